// File: rtl/hazard_unit_if.sv
// Decode-stage hazard interface: the decode side drives the instruction, the hazard unit
// answers with stall/forwarding controls and statistics.
interface hazard_unit_if #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    logic [31:0]      instr_in;
    logic             instr_valid;
    logic             flush;
    logic             stall;
    logic [SEL_W-1:0] fwd_a_sel;
    logic [SEL_W-1:0] fwd_b_sel;
    logic [SEL_W-1:0] inflight_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output instr_in, instr_valid, flush,
        input  stall, fwd_a_sel, fwd_b_sel, inflight_cnt, stall_cnt
    );

    modport slave (
        input  instr_in, instr_valid, flush,
        output stall, fwd_a_sel, fwd_b_sel, inflight_cnt, stall_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Load-use stall and forwarding-select unit for a MIPS subset; tracks the destinations
// of DEPTH in-flight instructions behind decode.
module hazard_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    hazard_unit_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } entry_t;

    entry_t           stage_q [DEPTH];
    logic [SEL_W-1:0] inflight_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [5:0] op, func;
    logic [4:0] rs, rt, rd;
    logic       rs_used, rt_used;
    entry_t     dec_entry;
    logic       stall_c;
    logic [SEL_W-1:0] fwd_a_c, fwd_b_c, inflight_d;
    logic       unused_shamt;

    assign op           = bus.instr_in[31:26];
    assign rs           = bus.instr_in[25:21];
    assign rt           = bus.instr_in[20:16];
    assign rd           = bus.instr_in[15:11];
    assign func         = bus.instr_in[5:0];
    assign unused_shamt = ^bus.instr_in[10:6];

    // Instruction decode: destination, operand usage and load flag.
    always_comb begin
        dec_entry = '0;
        rs_used   = 1'b0;
        rt_used   = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                rs_used = 1'b1;
                rt_used = (func != FN_JR);
                if (func == FN_SUBU || func == FN_NOR || func == FN_SLTU) begin
                    dec_entry.valid = 1'b1;
                    dec_entry.dest  = rd;
                end
            end
            OP_ADDI, OP_LW: begin
                rs_used           = 1'b1;
                dec_entry.valid   = 1'b1;
                dec_entry.dest    = rt;
                dec_entry.is_load = (op == OP_LW);
            end
            OP_SW: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            OP_BLTZ: rs_used = 1'b1;
            default: ;
        endcase
        // Writes to $0 are architecturally void, so they never become hazards.
        if (dec_entry.dest == 5'd0)
            dec_entry.valid = 1'b0;
    end

    // Load-use detection and youngest-first forwarding selection.
    always_comb begin
        stall_c = 1'b0;
        fwd_a_c = '0;
        fwd_b_c = '0;
        if (bus.instr_valid && !bus.flush && stage_q[0].valid && stage_q[0].is_load &&
            ((rs_used && stage_q[0].dest == rs) || (rt_used && stage_q[0].dest == rt)))
            stall_c = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (stage_q[i].valid && rs_used && stage_q[i].dest == rs)
                fwd_a_c = SEL_W'(i + 1);
            if (stage_q[i].valid && rt_used && stage_q[i].dest == rt)
                fwd_b_c = SEL_W'(i + 1);
        end
        if (stall_c) begin
            fwd_a_c = '0;
            fwd_b_c = '0;
        end
    end

    // Occupancy of the tracker after the coming shift.
    always_comb begin
        inflight_d = '0;
        if (bus.instr_valid && !stall_c && !bus.flush && dec_entry.valid)
            inflight_d = SEL_W'(1);
        for (int i = 0; i < DEPTH - 1; i++)
            inflight_d = inflight_d + SEL_W'(stage_q[i].valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                stage_q[i] <= '0;
            inflight_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--)
                stage_q[i] <= stage_q[i-1];
            if (bus.instr_valid && !stall_c && !bus.flush)
                stage_q[0] <= dec_entry;
            else
                stage_q[0] <= '0;
            inflight_q <= inflight_d;
            if (stall_c && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall        = stall_c;
    assign bus.fwd_a_sel    = fwd_a_c;
    assign bus.fwd_b_sel    = fwd_b_c;
    assign bus.inflight_cnt = inflight_q;
    assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a default instance (DEPTH=2, CNT_W=16) and a minimal
// one (DEPTH=1, CNT_W=2) driven with identical stimulus.
module tb_hazard_unit;
    localparam logic [31:0] ADDI1  = 32'h20010005;
    localparam logic [31:0] ADDI2  = 32'h20020007;
    localparam logic [31:0] ADDI3  = 32'h20030009;
    localparam logic [31:0] ADDI0  = 32'h20000005;
    localparam logic [31:0] SUBU11 = 32'h00211023;
    localparam logic [31:0] LW3    = 32'h8C030000;
    localparam logic [31:0] SUBU33 = 32'h00632023;
    localparam logic [31:0] SUBU00 = 32'h00001023;
    localparam logic [31:0] SUBU23 = 32'h00431023;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_unit_if #(.DEPTH(2), .CNT_W(16)) bus0 ();
    hazard_unit_if #(.DEPTH(1), .CNT_W(2))  bus1 ();

    hazard_unit #(.DEPTH(2), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    hazard_unit #(.DEPTH(1), .CNT_W(2))  u1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic drv(input logic [31:0] instr, input logic valid, input logic fl);
        bus0.instr_in = instr; bus0.instr_valid = valid; bus0.flush = fl;
        bus1.instr_in = instr; bus1.instr_valid = valid; bus1.flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle2();
        drv(32'h0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        drv(32'h0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_stall",    32'(bus0.stall), 32'd0);
        chk("rst_fwd_a",    32'(bus0.fwd_a_sel), 32'd0);
        chk("rst_fwd_b",    32'(bus0.fwd_b_sel), 32'd0);
        chk("rst_inflight", 32'(bus0.inflight_cnt), 32'd0);
        chk("rst_stallcnt", 32'(bus0.stall_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Back-to-back RAW: forward from stage 1.
        drv(ADDI1, 1'b1, 1'b0); tick();
        drv(SUBU11, 1'b1, 1'b0); #1;
        chk("b2b_fwd_a",   32'(bus0.fwd_a_sel), 32'd1);
        chk("b2b_fwd_b",   32'(bus0.fwd_b_sel), 32'd1);
        chk("b2b_stall",   32'(bus0.stall), 32'd0);
        chk("b2b_d1_fwd_a", 32'(bus1.fwd_a_sel), 32'd1);
        tick();
        chk("b2b_inflight", 32'(bus0.inflight_cnt), 32'd2);
        idle2();
        chk("drain_inflight", 32'(bus0.inflight_cnt), 32'd0);

        // One bubble between producer and consumer: forward from stage 2.
        drv(ADDI1, 1'b1, 1'b0); tick();
        drv(32'h0, 1'b0, 1'b0); tick();
        drv(SUBU11, 1'b1, 1'b0); #1;
        chk("gap_fwd_a",    32'(bus0.fwd_a_sel), 32'd2);
        chk("gap_fwd_b",    32'(bus0.fwd_b_sel), 32'd2);
        chk("gap_d1_fwd_a", 32'(bus1.fwd_a_sel), 32'd0);
        tick();
        idle2();

        // Load-use: one stall cycle, then forward from stage 2 (register file at DEPTH=1).
        drv(LW3, 1'b1, 1'b0); tick();
        drv(SUBU33, 1'b1, 1'b0); #1;
        chk("lu_stall",    32'(bus0.stall), 32'd1);
        chk("lu_fwd_a",    32'(bus0.fwd_a_sel), 32'd0);
        chk("lu_fwd_b",    32'(bus0.fwd_b_sel), 32'd0);
        chk("lu_d1_stall", 32'(bus1.stall), 32'd1);
        tick();
        chk("lu_stallcnt",    32'(bus0.stall_cnt), 32'd1);
        chk("lu_d1_stallcnt", 32'(bus1.stall_cnt), 32'd1);
        chk("lu2_stall",   32'(bus0.stall), 32'd0);
        chk("lu2_fwd_a",   32'(bus0.fwd_a_sel), 32'd2);
        chk("lu2_fwd_b",   32'(bus0.fwd_b_sel), 32'd2);
        chk("lu2_d1_stall", 32'(bus1.stall), 32'd0);
        chk("lu2_d1_fwd_a", 32'(bus1.fwd_a_sel), 32'd0);
        tick();
        idle2();

        // Flush beats load-use stall; flushed instruction never enters the tracker.
        drv(LW3, 1'b1, 1'b0); tick();
        drv(SUBU33, 1'b1, 1'b1); #1;
        chk("fl_stall",    32'(bus0.stall), 32'd0);
        chk("fl_d1_stall", 32'(bus1.stall), 32'd0);
        tick();
        chk("fl_inflight",    32'(bus0.inflight_cnt), 32'd1);
        chk("fl_d1_inflight", 32'(bus1.inflight_cnt), 32'd0);
        chk("fl_stallcnt",    32'(bus0.stall_cnt), 32'd1);
        idle2();

        // Three more load-use pairs: wide counter reaches 4, 2-bit counter holds at 3.
        for (int n = 0; n < 3; n++) begin
            drv(LW3, 1'b1, 1'b0); tick();
            drv(SUBU33, 1'b1, 1'b0); tick();
            tick();
            idle2();
        end
        chk("sat_stallcnt",    32'(bus0.stall_cnt), 32'd4);
        chk("sat_d1_stallcnt", 32'(bus1.stall_cnt), 32'd3);

        // Writes to $0 are never tracked.
        drv(ADDI0, 1'b1, 1'b0); tick();
        drv(SUBU00, 1'b1, 1'b0); #1;
        chk("r0_fwd_a",    32'(bus0.fwd_a_sel), 32'd0);
        chk("r0_fwd_b",    32'(bus0.fwd_b_sel), 32'd0);
        chk("r0_inflight", 32'(bus0.inflight_cnt), 32'd0);
        tick();
        idle2();

        // Mid-stream reset discards in-flight writers.
        drv(ADDI1, 1'b1, 1'b0); tick();
        drv(ADDI2, 1'b1, 1'b0); tick();
        drv(ADDI3, 1'b1, 1'b0); tick();
        drv(SUBU23, 1'b1, 1'b0); #1;
        chk("pre_rst_fwd_a", 32'(bus0.fwd_a_sel), 32'd2);
        chk("pre_rst_fwd_b", 32'(bus0.fwd_b_sel), 32'd1);
        rst = 1'b1; #1;
        chk("mid_rst_inflight", 32'(bus0.inflight_cnt), 32'd0);
        chk("mid_rst_fwd_a",    32'(bus0.fwd_a_sel), 32'd0);
        chk("mid_rst_fwd_b",    32'(bus0.fwd_b_sel), 32'd0);
        chk("mid_rst_stallcnt", 32'(bus0.stall_cnt), 32'd0);
        chk("mid_rst_d1_stallcnt", 32'(bus1.stall_cnt), 32'd0);
        tick();
        rst = 1'b0; #1;
        chk("post_rst_fwd_a", 32'(bus0.fwd_a_sel), 32'd0);
        chk("post_rst_fwd_b", 32'(bus0.fwd_b_sel), 32'd0);
        chk("post_rst_stall", 32'(bus0.stall), 32'd0);
        tick();
        chk("post_rst_inflight", 32'(bus0.inflight_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameter: DEPTH, default 2, number of tracked in-flight stages (legal 1..4).
REQ-003 Parameter: CNT_W, default 16, width of the stall statistics counter.
REQ-004 Derived: SEL_W = clog2(DEPTH+1).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 instr_in  in  32  MIPS word currently in decode.
REQ-008 instr_valid  in  1  instr_in holds a real instruction.
REQ-009 flush  in  1  kill the decode instruction (taken branch or jump).
REQ-010 stall  out  1  hold fetch/decode and inject a bubble this cycle.
REQ-011 fwd_a_sel  out  SEL_W  forwarding source for rs: 0 = register file, k = stage k.
REQ-012 fwd_b_sel  out  SEL_W  forwarding source for rt, same encoding.
REQ-013 inflight_cnt  out  SEL_W  number of valid tracked entries.
REQ-014 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-015 Decode: op = instr_in[31:26], rs = [25:21], rt = [20:16], rd = [15:11], func = [5:0].
REQ-016 Destination: op=0 with func in {100011 subu, 100111 nor, 101011 sltu} -> rd; op in {001000 addi, 100011 lw} -> rt; all others (jr, bltz, j, sw, unknown) -> none.
REQ-017 rs-used: every valid opcode except j (000010); rt-used: op=0 with func not 001000, or op=101011 (sw).
REQ-018 is_load: op=100011.
REQ-019 Tracker: DEPTH registered entries {valid, dest[4:0], is_load}; stage 1 = youngest; an entry with dest none or dest 0 SHALL be stored invalid.
REQ-020 Every clock: stage[k+1] <= stage[k] for k = 1..DEPTH-1; the entry in stage DEPTH retires.
REQ-021 stage[1] <= decoded instr_in when instr_valid & ~stall & ~flush; otherwise a bubble (valid=0).
REQ-022 fwd_a_sel SHALL be combinational: the smallest k with stage[k].valid, rs-used and stage[k].dest == rs; 0 if none; identical rule for fwd_b_sel with rt and rt-used.
REQ-023 Load-use: stall = 1 when instr_valid, stage[1].valid, stage[1].is_load, and stage[1].dest matches a used rs or rt; otherwise 0.
REQ-024 While stall = 1, fwd_a_sel and fwd_b_sel SHALL be 0.
REQ-025 A load in stage k >= 2 SHALL be forwarded normally, without a stall.
REQ-026 flush = 1 SHALL force stall = 0 in the same cycle; flush has priority over stall.
REQ-027 A stall lasts exactly one cycle per load-use pair: the bubble moves the load to stage 2, so the next cycle forwards with sel = 2.
REQ-028 When DEPTH = 1, a load-use pair SHALL stall for one cycle; after the load retires, fwd_sel = 0 (register file).
REQ-029 inflight_cnt SHALL equal the popcount of stage valids, registered with the tracker.
REQ-030 stall_cnt SHALL increment on each clock where stall = 1 and SHALL hold at 2^CNT_W-1.
REQ-031 rd or rt equal to 0 SHALL never produce a forward or a stall.

Reset
REQ-032 rst asserted SHALL, asynchronously, clear all entry valids, inflight_cnt and stall_cnt to 0; stall, fwd_a_sel and fwd_b_sel then evaluate to 0.
REQ-033 Reset asserted mid-stream SHALL discard all in-flight entries; the first instruction after release SHALL see no hazards.

Verification
REQ-034 addi 0x20010005, then subu 0x00211023 -> second cycle fwd_a_sel=1, fwd_b_sel=1, stall=0.
REQ-035 addi 0x20010005, one nop (instr_valid=0), then subu 0x00211023 -> fwd_a_sel=2, fwd_b_sel=2.
REQ-036 lw 0x8C030000, then subu 0x00632023 -> stall=1 for one cycle with sels 0 and stall_cnt=1; next cycle fwd_a_sel=fwd_b_sel=2, stall=0.
REQ-037 lw 0x8C030000, then subu 0x00632023 with flush=1 -> stall=0; the subu does not enter the tracker; inflight_cnt after 1 cycle = 1.
REQ-038 addi $0 (0x20000005), then subu reading $0 -> sels 0, inflight_cnt=0.
REQ-039 Three back-to-back writers, rst pulsed mid-stream -> inflight_cnt=0, sels 0 immediately; stall_cnt=0.
